// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the four-master round-robin bus arbiter:
// state encoding, channel count, master index width and signal polarities.
package bus_arbiter_rr_pkg;

    localparam int BUS_MASTER_CH   = 4;
    localparam int MIDX_W          = 2;
    localparam int TIMEOUT_CYC_DEF = 16;

    // Active-low bus signalling levels; reset is active-low as well.
    localparam logic ENABLE_      = 1'b0;
    localparam logic DISABLE_     = 1'b1;
    localparam logic RESET_ENABLE = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        WAIT    = 2'd2,
        ABORT   = 2'd3
    } state_e;

    // Active-low one-hot grant vector for master idx.
    function automatic logic [BUS_MASTER_CH-1:0] grant_vec(input logic [MIDX_W-1:0] idx);
        grant_vec = ~(BUS_MASTER_CH'(1) << idx);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: searches last_owner+1 .. last_owner+4 (mod 4) and
// returns the first master whose active-low request is asserted.
module bus_arbiter_rr_pick
    import bus_arbiter_rr_pkg::*;
(
    input  logic [BUS_MASTER_CH-1:0] req_,
    input  logic [MIDX_W-1:0]        last_owner,
    output logic [MIDX_W-1:0]        pick,
    output logic                     any_req
);

    logic [MIDX_W-1:0] cand;

    // Priority search starting just after the previous owner.
    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        pick    = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 1; i <= BUS_MASTER_CH; i++) begin
            // Index arithmetic wraps naturally in MIDX_W bits (+4 lands on last_owner).
            cand = last_owner + MIDX_W'(i);
            if (!any_req && req_[cand] == ENABLE_) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Four-master round-robin bus arbiter with an access watchdog. The grant is
// held until the owner releases its request; each as_/rdy_ access of the
// owner is timed and aborted with a one-cycle bus_err_ pulse if the slave
// never answers. All outputs are registered.
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUS_MASTER_CH-1:0] req_,
    input  logic [BUS_MASTER_CH-1:0] m_as_,
    input  logic                     s_rdy_,
    input  logic                     err_clr_,
    output logic [BUS_MASTER_CH-1:0] grnt_,
    output logic                     bus_busy,
    output logic                     bus_err_,
    output logic                     err_flag,
    output logic [MIDX_W-1:0]        err_owner
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e                   state_q, state_d;
    logic [MIDX_W-1:0]        last_owner_q, last_owner_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BUS_MASTER_CH-1:0] grnt_q, grnt_d;
    logic                     busy_q, busy_d;
    logic                     bus_err_q, bus_err_d;
    logic                     err_flag_q, err_flag_d;
    logic [MIDX_W-1:0]        err_owner_q, err_owner_d;

    logic [MIDX_W-1:0]        pick;
    logic                     any_req;

    // One picker serves both the idle grant and the release handover; while
    // a master owns the bus last_owner_q is that owner.
    bus_arbiter_rr_pick u_pick (
        .req_       (req_),
        .last_owner (last_owner_q),
        .pick       (pick),
        .any_req    (any_req)
    );

    // Next-state and registered-output logic for the arbitration FSM.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        grnt_d       = grnt_q;
        busy_d       = busy_q;
        bus_err_d    = DISABLE_;
        err_owner_d  = err_owner_q;
        err_flag_d   = (err_clr_ == ENABLE_) ? 1'b0 : err_flag_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grnt_d       = grant_vec(pick);
                    last_owner_d = pick;
                    state_d      = GRANTED;
                end
            end
            GRANTED: begin
                if (req_[last_owner_q] == DISABLE_) begin
                    // Release wins over a simultaneous strobe; hand over with no idle cycle.
                    if (any_req) begin
                        grnt_d       = grant_vec(pick);
                        last_owner_d = pick;
                    end else begin
                        grnt_d  = '1;
                        state_d = IDLE;
                    end
                end else if (m_as_[last_owner_q] == ENABLE_) begin
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A ready on the expiry edge still completes the access.
                if (s_rdy_ == ENABLE_) begin
                    busy_d  = 1'b0;
                    state_d = GRANTED;
                end else if (cnt_q == CNT_LAST) begin
                    bus_err_d   = ENABLE_;
                    err_flag_d  = 1'b1;
                    err_owner_d = last_owner_q;
                    grnt_d      = '1;
                    busy_d      = 1'b0;
                    state_d     = ABORT;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ABORT: begin
                // last_owner_q is kept so arbitration resumes after the aborted master.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q      <= IDLE;
            last_owner_q <= MIDX_W'(BUS_MASTER_CH - 1);
            cnt_q        <= '0;
            grnt_q       <= '1;
            busy_q       <= 1'b0;
            bus_err_q    <= DISABLE_;
            err_flag_q   <= 1'b0;
            err_owner_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            grnt_q       <= grnt_d;
            busy_q       <= busy_d;
            bus_err_q    <= bus_err_d;
            err_flag_q   <= err_flag_d;
            err_owner_q  <= err_owner_d;
        end
    end

    assign grnt_     = grnt_q;
    assign bus_busy  = busy_q;
    assign bus_err_  = bus_err_q;
    assign err_flag  = err_flag_q;
    assign err_owner = err_owner_q;

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Four-master round-robin arbiter with an access watchdog for the shared on-chip bus that the gpio, timer and uart slaves hang off.
- Grants one master at a time and holds the grant until that master releases its request.
- Tracks each as_/rdy_ transaction of the current owner and aborts it if the addressed slave never answers.
- Sits between the master request lines and the bus master multiplexer. The grant vector drives the mux select.

Parameters:
- TIMEOUT_CYC, 16: cycles an access may wait for rdy_ before it is aborted. Legal range is 2..255.
- CNT_W, 8: width of the watchdog counter. Must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- reset  in  1  synchronous reset, active-low. Sampled only on the clk rising edge.
- req_  in  4  per-master bus request, active-low.
- m_as_  in  4  per-master address strobe, active-low. Only the owner's bit is honoured.
- s_rdy_  in  1  muxed slave ready, active-low.
- err_clr_  in  1  clears err_flag, active-low.
- grnt_  out  4  one-hot grant, active-low. 4'b1111 means no owner.
- bus_busy  out  1  high while the owner has an access in flight.
- bus_err_  out  1  one-cycle abort pulse to the owner, active-low.
- err_flag  out  1  sticky timeout flag.
- err_owner  out  2  index of the master that timed out.

Behaviour:
- Reset: when reset is low at a posedge:
  - outputs: grnt_=4'b1111, bus_busy=0, bus_err_=1, err_flag=0, err_owner=0;
  - internal: state=IDLE, cnt=0, last_owner=3 (so master 0 wins first).
  - This applies mid-transaction too: the grant and any pending access are dropped and no bus_err_ pulse is generated.
- Round-robin pick: search order is last_owner+1, +2, +3, +4 (mod 4). The first bit found low in req_ wins.
- All outputs are registered. A request sampled at edge n gives grnt_ low from edge n onward, i.e. one cycle of latency.
- IDLE:
  - No request low: stay in IDLE.
  - Any request low: grant the pick, set last_owner=pick, go to GRANTED.
- GRANTED (owner o):
  - req_[o] high: release. If another request is low, hand over directly to the next pick in the same edge (no idle cycle). Otherwise grnt_=4'b1111 and go to IDLE. Release takes priority over a simultaneous m_as_[o].
  - req_[o] low and m_as_[o] low: go to WAIT with cnt=0 and bus_busy=1.
  - Requests from non-owners never preempt the owner.
- WAIT:
  - s_rdy_ low: return to GRANTED with bus_busy=0. The owner keeps the grant.
  - s_rdy_ high and cnt==TIMEOUT_CYC-1: go to ABORT.
  - Otherwise: cnt++.
  - req_ and m_as_ changes are ignored in WAIT; a master may not abandon an access.
  - If s_rdy_ goes low on the same edge the counter would expire, s_rdy_ wins and there is no abort.
- ABORT (exactly one cycle):
  - bus_err_=0, err_flag=1, err_owner=o, grnt_=4'b1111, bus_busy=0.
  - Next edge: bus_err_=1 and state goes to IDLE. last_owner stays o, so arbitration resumes with o+1.
- err_flag:
  - Set on ABORT entry; cleared when err_clr_ is low at an edge.
  - Simultaneous set and clear: set wins.
  - err_owner holds its value until the next abort.
- Invariants:
  - grnt_ is always one-hot-low or all ones.
  - bus_busy implies exactly one grant is active.
  - cnt saturates; it never wraps.

Decomposition:
- Shared header bus_arbiter.h holds:
  - state encodings IDLE/GRANTED/WAIT/ABORT (2-bit);
  - BUS_MASTER_CH=4;
  - the TIMEOUT_CYC default;
  - master index width 2.
  It reuses the existing ENABLE_/DISABLE_ and RESET_ENABLE defines, with reset polarity fixed to low.
- One combinational sub-module, rr_pick: inputs req_[3:0] and last_owner[1:0]; outputs pick[1:0] and any_req. Reused for both the IDLE grant and the GRANTED handover.
- Target RTL size: roughly 150-250 lines total.

Test Plan:
- Reset then single requester: hold reset low 3 cycles. Then req_=4'b1101 -> grnt_=4'b1101 one edge later. Release req_[1] -> grnt_=4'b1111 next edge, state IDLE.
- Round-robin fairness: req_=4'b0000 held, each owner releases after one access (s_rdy_ returned 1 cycle after m_as_) -> grant order 0,1,2,3,0. There are no idle cycles between grants.
- Normal access: owner 2 drives m_as_[2]=0, slave answers s_rdy_=0 three cycles later -> bus_busy=1 for 3 cycles, then 0. grnt_ stays 4'b1011 and no bus_err_.
- Timeout: TIMEOUT_CYC=16, owner 1 strobes and s_rdy_ stays high:
  - bus_err_ low exactly once, 16 cycles after WAIT entry;
  - err_flag=1, err_owner=2'd1, grnt_=4'b1111;
  - the next grant goes to master 2 if it is requesting.
- Boundary race: s_rdy_ goes low in the cycle cnt==15 -> no abort and err_flag stays 0. Separately, err_clr_ low in the same cycle as ABORT entry -> err_flag=1.
- Reset mid-WAIT: reset low for 1 edge while bus_busy=1 -> next cycle grnt_=4'b1111, bus_busy=0, bus_err_=1, err_flag=0. After reset, with all requests low, master 0 wins.
